count_sequencer: RTL and testbench

COUNT_SEQUENCER -- requirements
Module: count_sequencer

---
 rtl/count_sequencer.sv | 158 +++++++++++++++
 tb/tb_count_sequencer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/count_sequencer.sv
// Start/pause/restart count sequencer with terminal count and DONE-state display blink.
// Define COUNT_SEQUENCER_BCD_EN for a four-digit BCD count; the default build counts in binary.
module count_sequencer #(
  parameter logic [15:0] LIMIT       = 16'h9999,
  parameter int          BLINK_TICKS = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        tick,
  input  logic        trig,
  input  logic        mode,
  input  logic        start,
  input  logic        clr,
  output logic [15:0] count,
  output logic        running,
  output logic        done,
  output logic        blank
);

  // state | meaning
  // IDLE  | count held at 0, waiting for start
  // RUN   | advance events increment count
  // PAUSE | count frozen, start resumes
  // DONE  | count held at LIMIT, display blinks on tick

  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state;
  logic          mode_q;
  logic          adv;
  logic [15:0]   count_inc;
  logic [BW-1:0] blink_cnt;

  function automatic logic [15:0] inc_count(input logic [15:0] v);
    logic [15:0] r;
`ifdef COUNT_SEQUENCER_BCD_EN
    logic       carry;
    logic [3:0] nib;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      nib = v[i*4 +: 4];
      if (carry) begin
        // an illegal digit above 9 rolls over like 9 so the count keeps moving
        if (nib >= 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = nib + 4'd1;
          carry       = 1'b0;
        end
      end
    end
`else
    r = v + 16'd1;
`endif
    return r;
  endfunction

  // the switch is registered so a mode flip never looks like an advance
  assign adv       = mode_q ? trig : tick;
  assign count_inc = inc_count(count);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      mode_q    <= 1'b0;
      count     <= 16'd0;
      running   <= 1'b0;
      done      <= 1'b0;
      blank     <= 1'b0;
      blink_cnt <= '0;
    end else begin
      mode_q <= mode;
      if (clr) begin
        state     <= IDLE;
        count     <= 16'd0;
        running   <= 1'b0;
        done      <= 1'b0;
        blank     <= 1'b0;
        blink_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state   <= RUN;
              running <= 1'b1;
            end
          end
          RUN: begin
            if (adv) begin
              count <= count_inc;
              if (count_inc == LIMIT) begin
                state     <= DONE;
                running   <= 1'b0;
                done      <= 1'b1;
                blank     <= 1'b0;
                blink_cnt <= '0;
              end else if (start) begin
                state   <= PAUSE;
                running <= 1'b0;
              end
            end else if (count == LIMIT) begin
              state     <= DONE;
              running   <= 1'b0;
              done      <= 1'b1;
              blank     <= 1'b0;
              blink_cnt <= '0;
            end else if (start) begin
              state   <= PAUSE;
              running <= 1'b0;
            end
          end
          PAUSE: begin
            if (start) begin
              state   <= RUN;
              running <= 1'b1;
            end
          end
          DONE: begin
            if (start) begin
              state     <= RUN;
              count     <= 16'd0;
              running   <= 1'b1;
              done      <= 1'b0;
              blank     <= 1'b0;
              blink_cnt <= '0;
            end else if (tick) begin
              // blink runs off the raw tick whatever the advance source is
              if (blink_cnt == BLINK_LAST) begin
                blank     <= ~blank;
                blink_cnt <= '0;
              end else begin
                blink_cnt <= blink_cnt + 1'b1;
              end
            end
          end
          default: begin
            state     <= IDLE;
            count     <= 16'd0;
            running   <= 1'b0;
            done      <= 1'b0;
            blank     <= 1'b0;
            blink_cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_count_sequencer.sv
// Randomized bench for count_sequencer: two instances (small LIMIT with fast blink, default LIMIT)
// compared every cycle against a behavioural model, plus directed scenario checks.
module tb_count_sequencer;

  localparam logic [15:0] LIM_A = 16'h0004;
  localparam int          BLK_A = 2;
  localparam logic [15:0] LIM_B = 16'h9999;
  localparam int          BLK_B = 8;

  localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_PAUSE = 2'd2, S_DONE = 2'd3;

  typedef struct packed {
    logic [1:0]  st;
    logic [15:0] cnt;
    logic [7:0]  blink;
    logic        blank;
    logic        mode_q;
  } mdl_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic tick = 1'b0, trig = 1'b0, mode = 1'b0, start = 1'b0, clr = 1'b0;
  logic [15:0] a_count, b_count;
  logic a_running, a_done, a_blank, b_running, b_done, b_blank;

  int total = 0;
  int bad   = 0;
  mdl_t ma, mb;

  always #5 clock = ~clock;

  count_sequencer #(.LIMIT(LIM_A), .BLINK_TICKS(BLK_A)) dut_a (
    .clock(clock), .reset(reset), .tick(tick), .trig(trig), .mode(mode),
    .start(start), .clr(clr), .count(a_count), .running(a_running),
    .done(a_done), .blank(a_blank));

  count_sequencer #(.LIMIT(LIM_B), .BLINK_TICKS(BLK_B)) dut_b (
    .clock(clock), .reset(reset), .tick(tick), .trig(trig), .mode(mode),
    .start(start), .clr(clr), .count(b_count), .running(b_running),
    .done(b_done), .blank(b_blank));

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // decimal arithmetic on the digit value rather than nibble carries
  function automatic logic [15:0] model_inc(input logic [15:0] v);
`ifdef COUNT_SEQUENCER_BCD_EN
    int d;
    d = int'(v[15:12]) * 1000 + int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
    d = (d + 1) % 10000;
    return {4'(d / 1000), 4'((d / 100) % 10), 4'((d / 10) % 10), 4'(d % 10)};
`else
    return 16'((int'(v) + 1) % 65536);
`endif
  endfunction

  function automatic mdl_t reset_model();
    mdl_t m;
    m = '0;
    m.st = S_IDLE;
    return m;
  endfunction

  function automatic mdl_t model_next(input mdl_t m, input logic [15:0] lim, input int bt,
                                      input logic tk, input logic tg, input logic md,
                                      input logic st, input logic cl);
    mdl_t n;
    logic adv;
    logic [15:0] c;
    n = m;
    adv = m.mode_q ? tg : tk;
    n.mode_q = md;
    if (cl) begin
      n.st = S_IDLE; n.cnt = 0; n.blank = 0; n.blink = 0;
    end else if (m.st == S_IDLE) begin
      if (st) n.st = S_RUN;
    end else if (m.st == S_RUN) begin
      c = model_inc(m.cnt);
      if (adv) begin
        n.cnt = c;
        if (c == lim) n.st = S_DONE;
        else if (st) n.st = S_PAUSE;
      end else if (m.cnt == lim) n.st = S_DONE;
      else if (st) n.st = S_PAUSE;
      if (n.st == S_DONE) begin n.blank = 0; n.blink = 0; end
    end else if (m.st == S_PAUSE) begin
      if (st) n.st = S_RUN;
    end else begin
      if (st) begin
        n.st = S_RUN; n.cnt = 0; n.blank = 0; n.blink = 0;
      end else if (tk) begin
        if (int'(m.blink) + 1 >= bt) begin n.blank = ~m.blank; n.blink = 0; end
        else n.blink = m.blink + 8'd1;
      end
    end
    return n;
  endfunction

  task automatic compare_all();
    check_val("a_count",   32'(a_count),   32'(ma.cnt));
    check_val("a_running", 32'(a_running), 32'(ma.st == S_RUN));
    check_val("a_done",    32'(a_done),    32'(ma.st == S_DONE));
    check_val("a_blank",   32'(a_blank),   32'(ma.blank));
    check_val("b_count",   32'(b_count),   32'(mb.cnt));
    check_val("b_running", 32'(b_running), 32'(mb.st == S_RUN));
    check_val("b_done",    32'(b_done),    32'(mb.st == S_DONE));
    check_val("b_blank",   32'(b_blank),   32'(mb.blank));
  endtask

  // inputs applied here are sampled at the next rising edge; outputs checked 1 after it
  task automatic step(input logic tk, input logic tg, input logic st, input logic cl);
    tick = tk; trig = tg; start = st; clr = cl;
    @(posedge clock);
    ma = model_next(ma, LIM_A, BLK_A, tk, tg, mode, st, cl);
    mb = model_next(mb, LIM_B, BLK_B, tk, tg, mode, st, cl);
    #1;
    compare_all();
    tick = 0; trig = 0; start = 0; clr = 0;
  endtask

  task automatic async_reset();
    reset = 1'b0;
    #1;
    ma = reset_model();
    mb = reset_model();
    compare_all();
    @(posedge clock);
    #1;
    compare_all();
    reset = 1'b1;
  endtask

  initial begin
    ma = reset_model();
    mb = reset_model();
    #2;
    async_reset();
    check_val("reset_count", 32'(a_count), 32'h0);

    // start, 3 ticks, start (pause), 2 ignored ticks
    mode = 0;
    step(0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    for (int i = 0; i < 2; i++) step(1, 0, 0, 0);
    check_val("pause_count", 32'(a_count), 32'h3);
    check_val("pause_running", 32'(a_running), 32'h0);

    // manual mode: done on the edge count reaches LIMIT
    step(0, 0, 0, 1);
    mode = 1;
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0);
    check_val("done_at_limit", 32'(a_done), 32'h1);
    check_val("done_count", 32'(a_count), 32'h4);
    step(0, 1, 0, 0);
    check_val("done_hold", 32'(a_count), 32'h4);

    // blink sequence with BLINK_TICKS=2
    step(1, 0, 0, 0); check_val("blank_t1", 32'(a_blank), 32'h0);
    step(1, 0, 0, 0); check_val("blank_t2", 32'(a_blank), 32'h1);
    step(1, 0, 0, 0); check_val("blank_t3", 32'(a_blank), 32'h1);
    step(1, 0, 0, 0); check_val("blank_t4", 32'(a_blank), 32'h0);
    step(0, 0, 1, 0);
    check_val("restart_count", 32'(a_count), 32'h0);
    check_val("restart_running", 32'(a_running), 32'h1);
    check_val("restart_blank", 32'(a_blank), 32'h0);

    // clr beats start and tick in the same cycle
    mode = 0;
    step(0, 0, 0, 0);
    step(1, 0, 1, 1);
    check_val("clr_prio_count", 32'(a_count), 32'h0);
    check_val("clr_prio_running", 32'(a_running), 32'h0);

    // async reset mid-count at 5 on the default-limit instance
    step(0, 0, 1, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
    check_val("pre_reset_count", 32'(b_count), 32'h5);
    async_reset();
    check_val("rst_count", 32'(b_count), 32'h0);
    check_val("rst_running", 32'(b_running), 32'h0);
    check_val("rst_done", 32'(b_done), 32'h0);

    // count to 16'h0019 then one more advance
    step(0, 0, 1, 0);
    for (int i = 0; i < 40 && mb.cnt != 16'h0019; i++) step(1, 0, 0, 0);
    check_val("reach_0019", 32'(b_count), 32'h0019);
    step(1, 0, 0, 0);
`ifdef COUNT_SEQUENCER_BCD_EN
    check_val("inc_0019", 32'(b_count), 32'h0020);
`else
    check_val("inc_0019", 32'(b_count), 32'h001A);
`endif

    // randomized phase
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 399) == 0) async_reset();
      if ($urandom_range(0, 49) == 0) mode = ~mode;
      step(logic'($urandom_range(0, 9) < 3), logic'($urandom_range(0, 9) < 3),
           logic'($urandom_range(0, 19) == 0), logic'($urandom_range(0, 49) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
